// File: rtl/rpn_pkg.sv
// Shared types and defaults for the RPN operand stack: command opcodes, FSM states,
// default geometry and the RAM address-width helper.
package rpn_pkg;

   typedef enum logic [2:0] {
      OP_NOP      = 3'd0,
      OP_PUSH     = 3'd1,
      OP_POP      = 3'd2,
      OP_REPLACE2 = 3'd3,
      OP_SWAP     = 3'd4
   } stack_op_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_REFILL = 1'b1
   } fsm_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 16;

   // Address width for the spill RAM, which holds everything below top and next.
   function automatic int ram_aw(input int depth);
      return (depth > 4) ? $clog2(depth - 2) : 1;
   endfunction

endpackage

// File: rtl/rpn_operand_stack_if.sv
// Command/status bundle between the calculator (master) and the operand stack (slave).
// RPN_STACK_ERR_STICKY_EN adds the err_clr strobe from the master.
interface rpn_operand_stack_if #(
   parameter int WIDTH = rpn_pkg::DEF_WIDTH
);
   import rpn_pkg::*;

   logic             cmd_valid;
   stack_op_t        cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic             cmd_ready;
   logic [WIDTH-1:0] top;
   logic [WIDTH-1:0] next;
   logic [7:0]       counter;
   logic             err;

`ifdef RPN_STACK_ERR_STICKY_EN
   logic             err_clr;

   modport master (
      output cmd_valid, cmd_op, cmd_data, err_clr,
      input  cmd_ready, top, next, counter, err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, err_clr,
      output cmd_ready, top, next, counter, err
   );
`else
   modport master (
      output cmd_valid, cmd_op, cmd_data,
      input  cmd_ready, top, next, counter, err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data,
      output cmd_ready, top, next, counter, err
   );
`endif

endinterface

// File: rtl/rpn_stack_ram.sv
// Spill storage for stack entries below top/next: one synchronous write port,
// one synchronous read port with a registered output, no reset.
module rpn_stack_ram #(
   parameter int WIDTH   = 16,
   parameter int ENTRIES = 14,
   parameter int AW      = 4
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem [ENTRIES];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/rpn_operand_stack.sv
// RPN operand stack: top/next in registers, deeper entries spilled to RAM, one-cycle
// refill after POP/REPLACE2. Define RPN_STACK_ERR_STICKY_EN for a sticky err with err_clr.
module rpn_operand_stack
   import rpn_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   rpn_operand_stack_if.slave  bus
);

   localparam int         AW      = ram_aw(DEPTH);
   localparam logic [7:0] DEPTH_C = 8'(DEPTH);

   fsm_t             state_q, state_d;
   logic [WIDTH-1:0] top_q, top_d;
   logic [WIDTH-1:0] next_q, next_d;
   logic [7:0]       count_q, count_d;
   logic             err_q, err_d;
   logic             err_event;
   logic             accept;
   logic             refill_start;
   logic             ram_we, ram_re;
   logic [AW-1:0]    ram_waddr, ram_raddr;
   logic [WIDTH-1:0] ram_rdata;

   assign accept = bus.cmd_valid && (state_q == ST_IDLE);

   rpn_stack_ram #(
      .WIDTH   (WIDTH),
      .ENTRIES (DEPTH - 2),
      .AW      (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (next_q),
      .re_i    (ram_re),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = refill_start ? ST_REFILL : ST_IDLE;
         ST_REFILL: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Rejected commands are still consumed; they only raise err_event.
   always_comb begin
      top_d        = top_q;
      next_d       = next_q;
      count_d      = count_q;
      err_event    = 1'b0;
      ram_we       = 1'b0;
      ram_re       = 1'b0;
      refill_start = 1'b0;
      ram_waddr    = AW'(count_q - 8'd2);
      ram_raddr    = AW'(count_q - 8'd3);
      if (state_q == ST_REFILL) begin
         next_d = ram_rdata;
      end else if (accept) begin
         case (bus.cmd_op)
            OP_PUSH: begin
               if (count_q == DEPTH_C) begin
                  err_event = 1'b1;
               end else begin
                  ram_we  = (count_q >= 8'd2);
                  next_d  = top_q;
                  top_d   = bus.cmd_data;
                  count_d = count_q + 8'd1;
               end
            end
            OP_POP, OP_REPLACE2: begin
               if ((bus.cmd_op == OP_POP && count_q == 8'd0) ||
                   (bus.cmd_op == OP_REPLACE2 && count_q < 8'd2)) begin
                  err_event = 1'b1;
               end else begin
                  top_d   = (bus.cmd_op == OP_POP) ? next_q : bus.cmd_data;
                  count_d = count_q - 8'd1;
                  if (count_q >= 8'd3) begin
                     ram_re       = 1'b1;
                     refill_start = 1'b1;
                  end else begin
                     next_d = '0;
                  end
               end
            end
            OP_SWAP: begin
               if (count_q < 8'd2) begin
                  err_event = 1'b1;
               end else begin
                  top_d  = next_q;
                  next_d = top_q;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef RPN_STACK_ERR_STICKY_EN
   // A new error wins over a simultaneous clear.
   assign err_d = err_event | (err_q & ~bus.err_clr);
`else
   assign err_d = err_event;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         top_q   <= '0;
         next_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         top_q   <= top_d;
         next_q  <= next_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      bus.cmd_ready = (state_q == ST_IDLE);
      bus.top       = top_q;
      bus.next      = next_q;
      bus.counter   = count_q;
      bus.err       = err_q;
   end

endmodule

// File: tb/tb_rpn_operand_stack.sv
// Directed bench for rpn_operand_stack: each step pushes its expected outputs to a
// scoreboard queue, which is popped and compared one cycle after the command.
module tb_rpn_operand_stack;
   import rpn_pkg::*;

   typedef struct {
      string       tag;
      logic [15:0] top;
      logic [15:0] next;
      logic        chk_next;
      logic [7:0]  cnt;
      logic        err;
      logic        rdy;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_asserts = 0;
   int   n_fail    = 0;
   logic err_m     = 1'b0;
   logic clr_now   = 1'b0;
   exp_t sb[$];

   always #5 clk = ~clk;

   rpn_operand_stack_if #(.WIDTH(16)) bus ();

   rpn_operand_stack #(.WIDTH(16), .DEPTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic err_model(input logic prev, input logic ev, input logic clr);
`ifdef RPN_STACK_ERR_STICKY_EN
      return ev | (prev & ~clr);
`else
      return ev;
`endif
   endfunction

   task automatic cmp(input string tag, input string field, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
      end
   endtask

   task automatic check_out();
      exp_t e;
      e = sb.pop_front();
      cmp(e.tag, "top", bus.top, e.top);
      if (e.chk_next) cmp(e.tag, "next", bus.next, e.next);
      cmp(e.tag, "counter", 16'(bus.counter), 16'(e.cnt));
      cmp(e.tag, "err", 16'(bus.err), 16'(e.err));
      cmp(e.tag, "ready", 16'(bus.cmd_ready), 16'(e.rdy));
      $display("step %-12s top=%h next=%h counter=%0d err=%b ready=%b",
               e.tag, bus.top, bus.next, bus.counter, bus.err, bus.cmd_ready);
   endtask

   task automatic expect_push(input string tag, input logic ev, input logic [15:0] et,
                              input logic [15:0] en, input logic cn, input logic [7:0] ec,
                              input logic er);
      exp_t e;
      err_m = err_model(err_m, ev, clr_now);
      e.tag = tag; e.top = et; e.next = en; e.chk_next = cn;
      e.cnt = ec; e.err = err_m; e.rdy = er;
      sb.push_back(e);
   endtask

   // Drive one command for one clock, then compare against the queued expectation.
   task automatic do_cmd(input string tag, input stack_op_t op, input logic [15:0] d,
                         input logic ev, input logic [15:0] et, input logic [15:0] en,
                         input logic cn, input logic [7:0] ec, input logic er);
      expect_push(tag, ev, et, en, cn, ec, er);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_NOP;
      bus.cmd_data  = '0;
      clr_now       = 1'b0;
`ifdef RPN_STACK_ERR_STICKY_EN
      bus.err_clr   = 1'b0;
`endif
      check_out();
   endtask

   task automatic idle(input string tag, input logic [15:0] et, input logic [15:0] en,
                       input logic [7:0] ec);
      expect_push(tag, 1'b0, et, en, 1'b1, ec, 1'b1);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic pulse_clear(input logic [15:0] et, input logic [15:0] en, input logic [7:0] ec);
`ifdef RPN_STACK_ERR_STICKY_EN
      bus.err_clr = 1'b1;
      clr_now     = 1'b1;
`endif
      do_cmd("err_clr", OP_NOP, 16'h0, 1'b0, et, en, 1'b1, ec, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_NOP;
      bus.cmd_data  = '0;
`ifdef RPN_STACK_ERR_STICKY_EN
      bus.err_clr   = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      err_m = 1'b0;
      expect_push("reset", 1'b0, 16'h0, 16'h0, 1'b1, 8'd0, 1'b1);
      check_out();

      do_cmd("push11", OP_PUSH, 16'h0011, 1'b0, 16'h0011, 16'h0000, 1'b1, 8'd1, 1'b1);
      do_cmd("push22", OP_PUSH, 16'h0022, 1'b0, 16'h0022, 16'h0011, 1'b1, 8'd2, 1'b1);
      do_cmd("push33", OP_PUSH, 16'h0033, 1'b0, 16'h0033, 16'h0022, 1'b1, 8'd3, 1'b1);
      do_cmd("pop", OP_POP, 16'h0, 1'b0, 16'h0022, 16'h0, 1'b0, 8'd2, 1'b0);
      // Offered during the refill cycle; must be ignored.
      do_cmd("ignored", OP_PUSH, 16'hBEEF, 1'b0, 16'h0022, 16'h0011, 1'b1, 8'd2, 1'b1);
      do_cmd("swap", OP_SWAP, 16'h0, 1'b0, 16'h0011, 16'h0022, 1'b1, 8'd2, 1'b1);
      do_cmd("replace2", OP_REPLACE2, 16'h0033, 1'b0, 16'h0033, 16'h0000, 1'b1, 8'd1, 1'b1);
      do_cmd("swap_err", OP_SWAP, 16'h0, 1'b1, 16'h0033, 16'h0000, 1'b1, 8'd1, 1'b1);
      do_cmd("nop", OP_NOP, 16'h0, 1'b0, 16'h0033, 16'h0000, 1'b1, 8'd1, 1'b1);
      pulse_clear(16'h0033, 16'h0000, 8'd1);
      do_cmd("repl_err", OP_REPLACE2, 16'h0044, 1'b1, 16'h0033, 16'h0000, 1'b1, 8'd1, 1'b1);
      pulse_clear(16'h0033, 16'h0000, 8'd1);
      do_cmd("pop_last", OP_POP, 16'h0, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'd0, 1'b1);
      do_cmd("pop_empty", OP_POP, 16'h0, 1'b1, 16'h0000, 16'h0000, 1'b1, 8'd0, 1'b1);
      idle("idle_err", 16'h0000, 16'h0000, 8'd0);
      pulse_clear(16'h0000, 16'h0000, 8'd0);

      for (int i = 0; i < 16; i++) begin
         do_cmd($sformatf("fill%0d", i), OP_PUSH, 16'(i), 1'b0, 16'(i),
                (i > 0) ? 16'(i - 1) : 16'h0, 1'b1, 8'(i + 1), 1'b1);
      end
      do_cmd("overflow", OP_PUSH, 16'hFFFF, 1'b1, 16'd15, 16'd14, 1'b1, 8'd16, 1'b1);
      pulse_clear(16'd15, 16'd14, 8'd16);

      for (int k = 0; k < 16; k++) begin
         c = 16 - k;
         if (c >= 3) begin
            do_cmd($sformatf("drain%0d", k), OP_POP, 16'h0, 1'b0, 16'(c - 2), 16'h0,
                   1'b0, 8'(c - 1), 1'b0);
            idle($sformatf("refill%0d", k), 16'(c - 2), 16'(c - 3), 8'(c - 1));
         end else begin
            do_cmd($sformatf("drain%0d", k), OP_POP, 16'h0, 1'b0,
                   (c == 2) ? 16'h0 : 16'h0, 16'h0, 1'b1, 8'(c - 1), 1'b1);
         end
      end
      do_cmd("under2", OP_POP, 16'h0, 1'b1, 16'h0, 16'h0, 1'b1, 8'd0, 1'b1);
      pulse_clear(16'h0000, 16'h0000, 8'd0);

      do_cmd("p_a", OP_PUSH, 16'h00A1, 1'b0, 16'h00A1, 16'h0000, 1'b1, 8'd1, 1'b1);
      do_cmd("p_b", OP_PUSH, 16'h00B2, 1'b0, 16'h00B2, 16'h00A1, 1'b1, 8'd2, 1'b1);
      do_cmd("p_c", OP_PUSH, 16'h00C3, 1'b0, 16'h00C3, 16'h00B2, 1'b1, 8'd3, 1'b1);
      do_cmd("pop_rst", OP_POP, 16'h0, 1'b0, 16'h00B2, 16'h0, 1'b0, 8'd2, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      err_m = 1'b0;
      expect_push("rst_refill", 1'b0, 16'h0, 16'h0, 1'b1, 8'd0, 1'b1);
      check_out();
      idle("after_rst", 16'h0, 16'h0, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
